// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM address map constants and fill FSM state type
package vram_pkg;
    localparam int VRAM_ADDR_WIDTH = 12;
    localparam logic [11:0] PMB_BASE = 12'h200;
    localparam logic [11:0] NTBL_BASE = 12'h400;
    localparam logic [11:0] NTBL_END = 12'h800;
    localparam int NTBL_COLORS = 960;
    typedef enum logic {IDLE, FILL} fill_state_t;
endpackage

// File: rtl/vram_write_scheduler_fifo.sv
// sync_fifo_m: synchronous FIFO with occupancy count; a push is visible at the head only after its edge
module sync_fifo_m #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: CPU write FIFO drained in the writable window, plus block-fill engine when VRAM_FILL_EN is defined
module vram_write_scheduler
    import vram_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W = VRAM_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          writable,
    input  logic                          cpu_valid,
    output logic                          cpu_ready,
    input  logic [ADDR_W-1:0]             cpu_address,
    input  logic [7:0]                    cpu_data,
    input  logic                          fill_start,
    input  logic [ADDR_W-1:0]             fill_base,
    input  logic [10:0]                   fill_len,
    input  logic [7:0]                    fill_value,
    output logic                          fill_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [ADDR_W-1:0]             address,
    output logic [7:0]                    data_in,
    output logic                          write_enable
);
    logic [ADDR_W+7:0] head;
    logic full, empty, push, pop, fill_we;
    logic [ADDR_W-1:0] fill_ptr;
    logic [7:0] fill_val;
    assign cpu_ready = !rst && !full;
    assign push = cpu_valid && cpu_ready;
    assign pop = !rst && writable && !empty;
    sync_fifo_m #(.WIDTH(ADDR_W + 8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({cpu_address, cpu_data}),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );
`ifdef VRAM_FILL_EN
    fill_state_t state, next_state;
    logic [10:0] remaining;
    logic start;
    assign start = state == IDLE && fill_start && fill_len != '0;
    // fill only gets the port when the CPU FIFO has nothing to write
    assign fill_we = writable && empty && state == FILL;
    assign fill_busy = state == FILL;
    always_comb begin
        next_state = start ? FILL : state;
        if (fill_we && remaining == 11'd1) next_state = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fill_ptr <= '0;
            remaining <= '0;
            fill_val <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                fill_ptr <= fill_base;
                remaining <= fill_len;
                fill_val <= fill_value;
            end else if (fill_we) begin
                fill_ptr <= fill_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end
`else
    logic unused_fill;
    assign unused_fill = ^{fill_start, fill_base, fill_len, fill_value};
    assign fill_we = 1'b0;
    assign fill_ptr = '0;
    assign fill_val = '0;
    assign fill_busy = 1'b0;
`endif
    assign write_enable = pop || (!rst && fill_we);
    assign address = rst ? '0 : !empty ? head[ADDR_W+7:8] : fill_ptr;
    assign data_in = rst ? '0 : !empty ? head[7:0] : fill_val;
endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb_vram_write_scheduler: directed and random tests against a queue-based write model
module tb_vram_write_scheduler;
    localparam int DEPTH = 16;
    typedef struct {logic [11:0] a; logic [7:0] d;} ent_t;
    typedef struct {int c; logic [11:0] a; logic [7:0] d;} wr_t;
    logic clk = 1'b0;
    logic rst, writable, cpu_valid, fill_start;
    logic cpu_ready, fill_busy, write_enable;
    logic [11:0] cpu_address, fill_base, address;
    logic [7:0] cpu_data, fill_value, data_in;
    logic [10:0] fill_len;
    logic [4:0] fifo_count;
    int checks = 0, failures = 0, cyc = 0;
    ent_t q[$];
    wr_t log_q[$];
    int f_rem = 0;
    logic [11:0] f_ptr = '0;
    logic [7:0] f_val = '0;
    int m_sz;
    bit m_idle, m_we;
    logic [19:0] m_exp;

    vram_write_scheduler dut (
        .clk(clk), .rst(rst), .writable(writable), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_address(cpu_address), .cpu_data(cpu_data), .fill_start(fill_start), .fill_base(fill_base),
        .fill_len(fill_len), .fill_value(fill_value), .fill_busy(fill_busy), .fifo_count(fifo_count),
        .address(address), .data_in(data_in), .write_enable(write_enable)
    );

    always #5 clk = ~clk;

    // reference model: pending CPU writes as a queue, fill as pointer plus bytes left
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            f_rem = 0;
        end else begin
            m_sz = q.size();
            m_idle = f_rem == 0;
            if (writable && m_sz > 0) q.delete(0);
            else if (writable && f_rem > 0) begin
                f_ptr++;
                f_rem--;
            end
            if (cpu_valid && m_sz < DEPTH) q.push_back('{a: cpu_address, d: cpu_data});
`ifdef VRAM_FILL_EN
            if (m_idle && fill_start && fill_len != 0) begin
                f_ptr = fill_base;
                f_rem = int'(fill_len);
                f_val = fill_value;
            end
`endif
        end
    end

    always @(negedge clk) begin
        m_we = !rst && writable && (q.size() > 0 || f_rem > 0);
        checks++;
        if (write_enable !== m_we) begin
            failures++;
            $display("FAIL mon_we cyc=%0d got=%b exp=%b", cyc, write_enable, m_we);
        end
        if (rst) begin
            checks++;
            if ({address, data_in} !== 20'h0) begin
                failures++;
                $display("FAIL mon_rst_out cyc=%0d got=%h exp=00000", cyc, {address, data_in});
            end
        end else if (m_we) begin
            m_exp = q.size() > 0 ? {q[0].a, q[0].d} : {f_ptr, f_val};
            checks++;
            if ({address, data_in} !== m_exp) begin
                failures++;
                $display("FAIL mon_wr cyc=%0d got=%h exp=%h", cyc, {address, data_in}, m_exp);
            end
        end
        checks++;
        if (cpu_ready !== (!rst && q.size() < DEPTH)) begin
            failures++;
            $display("FAIL mon_ready cyc=%0d got=%b exp=%b", cyc, cpu_ready, !rst && q.size() < DEPTH);
        end
        if (!rst) begin
            checks++;
            if (fifo_count !== 5'(q.size())) begin
                failures++;
                $display("FAIL mon_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, q.size());
            end
            checks++;
            if (fill_busy !== (f_rem > 0)) begin
                failures++;
                $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, fill_busy, f_rem > 0);
            end
        end
        if (write_enable === 1'b1) log_q.push_back('{c: cyc, a: address, d: data_in});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        #1;
        checks++;
        if ({fifo_count, cpu_ready, write_enable, fill_busy} !== 8'b00000_100) begin
            failures++;
            $display("FAIL reset_state got=%b exp=00000100", {fifo_count, cpu_ready, write_enable, fill_busy});
        end
    endtask

    task automatic test_deferred();
        writable = 1'b0;
        cpu_valid = 1'b1;
        cpu_address = 12'h400;
        cpu_data = 8'hAA;
        tick(1);
        cpu_valid = 1'b0;
        log_q.delete();
        tick(50);
        checks++;
        if (log_q.size() != 0 || fifo_count !== 5'd1) begin
            failures++;
            $display("FAIL deferred_hold writes=%0d count=%0d exp writes=0 count=1", log_q.size(), fifo_count);
        end
        writable = 1'b1;
        tick(4);
        checks++;
        if (log_q.size() != 1 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL deferred_drain writes=%0d count=%0d exp writes=1 count=0", log_q.size(), fifo_count);
        end else begin
            checks++;
            if ({log_q[0].a, log_q[0].d} !== 20'h400AA) begin
                failures++;
                $display("FAIL deferred_data got=%h exp=400aa", {log_q[0].a, log_q[0].d});
            end
        end
        writable = 1'b0;
    endtask

    task automatic test_full();
        ent_t exp_q[$];
        writable = 1'b0;
        cpu_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cpu_address = 12'($urandom);
            cpu_data = 8'($urandom);
            exp_q.push_back('{a: cpu_address, d: cpu_data});
            tick(1);
        end
        cpu_address = 12'($urandom);
        cpu_data = 8'($urandom);
        tick(3);
        checks++;
        if (cpu_ready !== 1'b0 || fifo_count !== 5'd16) begin
            failures++;
            $display("FAIL full_hold ready=%b count=%0d exp ready=0 count=16", cpu_ready, fifo_count);
        end
        cpu_valid = 1'b0;
        log_q.delete();
        writable = 1'b1;
        tick(20);
        checks++;
        if (log_q.size() != DEPTH) begin
            failures++;
            $display("FAIL full_drain_count got=%0d exp=%0d", log_q.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if ({log_q[i].a, log_q[i].d} !== {exp_q[i].a, exp_q[i].d} || (i > 0 && log_q[i].c != log_q[i-1].c + 1)) begin
                    failures++;
                    $display("FAIL full_drain_order idx=%0d got=%h exp=%h", i, {log_q[i].a, log_q[i].d}, {exp_q[i].a, exp_q[i].d});
                end
            end
        end
        writable = 1'b0;
    endtask

`ifdef VRAM_FILL_EN
    task automatic test_fill_boundary();
        logic [11:0] ea;
        log_q.delete();
        writable = 1'b1;
        fill_base = 12'h7FE;
        fill_len = 11'd4;
        fill_value = 8'h00;
        fill_start = 1'b1;
        tick(1);
        fill_start = 1'b0;
        checks++;
        if (fill_busy !== 1'b1) begin
            failures++;
            $display("FAIL fill_busy_start got=%b exp=1", fill_busy);
        end
        tick(6);
        checks++;
        if (log_q.size() != 4 || fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_len4 writes=%0d busy=%b exp writes=4 busy=0", log_q.size(), fill_busy);
        end else begin
            ea = 12'h7FE;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({log_q[i].a, log_q[i].d} !== {ea, 8'h00} || (i > 0 && log_q[i].c != log_q[i-1].c + 1)) begin
                    failures++;
                    $display("FAIL fill_addr idx=%0d got=%h exp=%h", i, {log_q[i].a, log_q[i].d}, {ea, 8'h00});
                end
                ea++;
            end
        end
        log_q.delete();
        fill_base = 12'hFFF;
        fill_len = 11'd2;
        fill_value = 8'h5A;
        fill_start = 1'b1;
        tick(1);
        fill_start = 1'b0;
        tick(4);
        checks++;
        if (log_q.size() != 2 || {log_q[0].a, log_q[1].a} !== 24'hFFF000) begin
            failures++;
            $display("FAIL fill_wrap writes=%0d exp=2 with fff then 000", log_q.size());
        end
        log_q.delete();
        fill_len = 11'd0;
        fill_start = 1'b1;
        tick(1);
        fill_start = 1'b0;
        checks++;
        if (fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_zero_busy got=%b exp=0", fill_busy);
        end
        tick(3);
        checks++;
        if (log_q.size() != 0) begin
            failures++;
            $display("FAIL fill_zero_writes got=%0d exp=0", log_q.size());
        end
    endtask

    task automatic test_fill_preempt();
        int j;
        logic [11:0] ea;
        log_q.delete();
        writable = 1'b1;
        fill_base = 12'h400;
        fill_len = 11'd10;
        fill_value = 8'($urandom);
        fill_start = 1'b1;
        tick(1);
        fill_start = 1'b0;
        tick(2);
        cpu_valid = 1'b1;
        cpu_address = 12'h200;
        cpu_data = 8'h55;
        tick(1);
        cpu_valid = 1'b0;
        tick(15);
        checks++;
        if (log_q.size() != 11) begin
            failures++;
            $display("FAIL preempt_count got=%0d exp=11", log_q.size());
        end else begin
            checks++;
            if ({log_q[3].a, log_q[3].d} !== 20'h20055) begin
                failures++;
                $display("FAIL preempt_cpu got=%h exp=20055", {log_q[3].a, log_q[3].d});
            end
            j = 0;
            ea = 12'h400;
            for (int i = 0; i < 11; i++) begin
                if (i != 3) begin
                    checks++;
                    if ({log_q[i].a, log_q[i].d} !== {ea, fill_value}) begin
                        failures++;
                        $display("FAIL preempt_fill idx=%0d got=%h exp=%h", i, {log_q[i].a, log_q[i].d}, {ea, fill_value});
                    end
                    ea++;
                    j++;
                end
            end
        end
    endtask
`else
    task automatic test_fill_disabled();
        log_q.delete();
        writable = 1'b1;
        fill_base = 12'h400;
        fill_len = 11'd10;
        fill_value = 8'hC3;
        fill_start = 1'b1;
        tick(1);
        fill_start = 1'b0;
        tick(12);
        checks++;
        if (log_q.size() != 0 || fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_disabled writes=%0d busy=%b exp writes=0 busy=0", log_q.size(), fill_busy);
        end
    endtask
`endif

    task automatic test_reset_mid();
        writable = 1'b1;
        fill_base = 12'h400;
        fill_len = 11'd20;
        fill_value = 8'h11;
        fill_start = 1'b1;
        tick(1);
        fill_start = 1'b0;
        tick(3);
        writable = 1'b0;
        cpu_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_address = 12'($urandom);
            cpu_data = 8'($urandom);
            tick(1);
        end
        cpu_valid = 1'b0;
        checks++;
        if (fifo_count !== 5'd5) begin
            failures++;
            $display("FAIL rstmid_pending got=%0d exp=5", fifo_count);
        end
        log_q.delete();
        writable = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        #1;
        checks++;
        if ({fifo_count, fill_busy, write_enable} !== 7'b0) begin
            failures++;
            $display("FAIL rstmid_state got=%b exp=0000000", {fifo_count, fill_busy, write_enable});
        end
        tick(5);
        checks++;
        if (log_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_writes got=%0d exp=0", log_q.size());
        end
        writable = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 499) == 0;
            writable = $urandom_range(0, 2) != 0;
            cpu_valid = $urandom_range(0, 1) == 1;
            cpu_address = 12'($urandom);
            cpu_data = 8'($urandom);
            fill_start = $urandom_range(0, 39) == 0;
            fill_base = 12'($urandom);
            fill_len = 11'($urandom_range(0, 30));
            fill_value = 8'($urandom);
            tick(1);
        end
        {rst, cpu_valid, fill_start} = 3'b000;
        writable = 1'b1;
        tick(60);
        checks++;
        if (fifo_count !== 5'd0 || fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL random_drain count=%0d busy=%b exp count=0 busy=0", fifo_count, fill_busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        {writable, cpu_valid, fill_start} = 3'b000;
        cpu_address = '0;
        cpu_data = '0;
        fill_base = '0;
        fill_len = '0;
        fill_value = '0;
        test_reset();
        test_deferred();
        test_full();
`ifdef VRAM_FILL_EN
        test_fill_boundary();
        test_fill_preempt();
`else
        test_fill_disabled();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Sits between the CPU-side bus and the VRAM write interface of the background and other VRAM consumers.
- Buffers CPU VRAM writes in a FIFO and drains them only while `writable` is high, so writes outside the blanking window are deferred rather than dropped.
- Optionally runs a block-fill engine (for example, a nametable clear) that shares the single VRAM write port with the CPU FIFO.
- The CPU FIFO always has priority over the fill engine.

Parameters:
- FIFO_DEPTH, 16, CPU write FIFO entries; power of two, 2..64.
- ADDR_W, `VRAM_ADDR_WIDTH (12), VRAM address width.

Ports:
- clk  in  1  pixel clock (12.5875 MHz)
- rst  in  1  synchronous, active-high reset
- writable  in  1  VRAM write window from video timing
- cpu_valid  in  1  CPU write request
- cpu_ready  out  1  FIFO can accept; transfer occurs when valid&&ready
- cpu_address  in  ADDR_W  CPU write address
- cpu_data  in  8  CPU write data
- fill_start  in  1  one-cycle pulse: start block fill
- fill_base  in  ADDR_W  first fill address
- fill_len  in  11  number of bytes, 0..1024
- fill_value  in  8  fill byte
- fill_busy  out  1  fill engine active
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- address  out  ADDR_W  VRAM write address
- data_in  out  8  VRAM write data
- write_enable  out  1  VRAM write strobe

Behaviour:
- Reset: synchronous, active-high (`rst` sampled on posedge `clk`). Reset values:
  - FIFO empty, fifo_count=0, cpu_ready=0 during the reset cycle and 1 after.
  - fill_busy=0, FSM in IDLE.
  - write_enable=0, address=0, data_in=0 (combinationally gated by rst).
- Outputs address, data_in and write_enable are combinational from the FIFO head or fill counter. The VRAM samples them on the same edge as the pop.
- cpu_ready = (fifo_count < FIFO_DEPTH). It is registered-state only, with no dependency on the pop.
  - Consequence: push while full is refused even if a pop happens in the same cycle.
- Push/pop latency: a push at edge t is visible at the head after t. The earliest write_enable is in the cycle after the push.
- Arbitration, evaluated each cycle:
  - If writable && FIFO non-empty: write_enable=1 with the head entry; pop on the edge.
  - Else if writable && FIFO empty && FSM=FILL: write_enable=1, address=fill_ptr, data_in=fill_value_q.
  - Otherwise write_enable=0.
- Simultaneous push and pop with FIFO not full: both occur; count is unchanged.
- FSM states: IDLE, FILL.
  - IDLE→FILL on fill_start && fill_len!=0. Latch fill_ptr=fill_base, remaining=fill_len, fill_value_q=fill_value.
  - fill_len=0: ignored; stays IDLE.
  - FILL: each fill write advances fill_ptr+1 (wraps modulo 2^ADDR_W) and decrements remaining.
  - FILL→IDLE on the edge where the write with remaining==1 occurs.
  - fill_start while in FILL is ignored. Inputs are latched only at start.
- fill_busy = (state==FILL).
- writable low mid-fill: the fill pauses and the pointer is held. CPU pushes during a fill are accepted and preempt the fill.
- rst during a fill or with a non-empty FIFO: all pending writes are discarded; no write_enable in the reset cycle.
- No address range filtering; downstream blocks decode their own regions.

Optional Feature:
- Macro: VRAM_FILL_EN.
- Defined: fill engine and FSM present as above.
- Undefined: fill_* inputs are ignored, fill_busy is tied 0, no FSM is instantiated, and only the FIFO drives the write port. Port list is identical in both cases.

Decomposition:
- Package vram_pkg holds:
  - VRAM_ADDR_WIDTH.
  - Region bases: PMB 12'h200, NTBL 12'h400, NTBL end 12'h800.
  - NTBL_COLORS offset 960.
  - The fill_state_t enum {IDLE, FILL}.
- One sub-module: sync_fifo_m (parameterised width/depth, synchronous reset, count output, no fall-through bypass).

Test Plan:
1. Push 0x400←0xAA with writable=0 for 50 cycles, then writable=1 → write_enable asserts exactly once, address=0x400, data_in=0xAA, fifo_count 1→0.
2. writable=0, push 17 entries (FIFO_DEPTH=16) → cpu_ready drops after the 16th push and the 17th is held. With writable=1, 16 writes issue in push order on consecutive cycles.
3. fill_start with base=0x7FE, len=4, value=0x00, writable=1 → writes to 0x7FE, 0x7FF, 0x800, 0x801 on 4 cycles; fill_busy high for 4 cycles, then IDLE.
4. Fill base=0x400, len=10; push 0x200←0x55 on fill cycle 3 → CPU write appears before the remaining fill writes; fill completes with 10 total fill writes and no duplicates.
5. base=0xFFF, len=2 → addresses 0xFFF then 0x000 (wrap). fill_len=0 → fill_busy stays 0 and no writes issue.
6. rst mid-fill with 5 FIFO entries pending → in the cycle after reset: fifo_count=0, fill_busy=0, write_enable=0, even with writable=1.
